// File: rtl/fmap_layer_sequencer_pkg.sv
// Shared constants for the feature-map layer sequencer: default geometry,
// FSM state encodings and a width helper that never returns zero.
package fmap_layer_sequencer_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LANES      = 32;
  localparam int DEF_WIDTH      = 7;
  localparam int DEF_NUM_LAYERS = 3;
  localparam int DEF_DRAIN_TO   = 1024;
  localparam int DEF_PIX_W      = DEF_DATA_WIDTH * DEF_LANES;
  localparam int DEF_DIM        = DEF_WIDTH * DEF_WIDTH;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_SWAP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  // Select/address fields must stay at least one bit wide, even for 1-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_layer_sequencer_if.sv
// Host/result port plus engine streaming port of the layer sequencer.
interface fmap_layer_sequencer_if #(
  parameter int PIX_W = 1024,
  parameter int AW    = 6,
  parameter int LW    = 2
);

  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [PIX_W-1:0] ld_data;
  logic             start;
  logic [AW-1:0]    res_addr;
  logic [PIX_W-1:0] res_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [LW-1:0]    layer_idx;
  logic             layer_clr;
  logic             l_valid_in;
  logic [PIX_W-1:0] l_data_in;
  logic             l_valid_out;
  logic [PIX_W-1:0] l_data_out;

  modport master (
    output ld_en, ld_addr, ld_data, start, res_addr, l_valid_out, l_data_out,
    input  res_data, busy, done, err, layer_idx, layer_clr, l_valid_in, l_data_in
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, start, res_addr, l_valid_out, l_data_out,
    output res_data, busy, done, err, layer_idx, layer_clr, l_valid_in, l_data_in
  );

endinterface

// File: rtl/fmap_layer_sequencer_bank.sv
// One ping-pong feature-map bank: 1R1W synchronous RAM with registered read.
module fmap_layer_sequencer_bank #(
  parameter int DEPTH = 49,
  parameter int PIX_W = 1024,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset so the result port reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/fmap_layer_sequencer.sv
// Runs a chain of conv layers over one feature map, ping-ponging between two
// banks: feed the source bank to the engine, capture its outputs into the other.
module fmap_layer_sequencer
  import fmap_layer_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int DRAIN_TO   = DEF_DRAIN_TO
) (
  input  logic                  clk,
  input  logic                  rst,
  fmap_layer_sequencer_if.slave bus
);

  localparam int PIX_W = DATA_WIDTH * LANES;
  localparam int DIM   = WIDTH * WIDTH;
  localparam int AW    = clog2_min1(DIM);
  localparam int CW    = clog2_min1(DIM + 1);
  localparam int LW    = clog2_min1(NUM_LAYERS);
  localparam int TW    = clog2_min1(DRAIN_TO + 1);

  logic [2:0]       state;
  logic             src;
  logic [LW-1:0]    layer_idx;
  logic [CW-1:0]    rd_cnt;
  logic [CW-1:0]    wr_cnt;
  logic [TW-1:0]    to_cnt;
  logic             feed_vld;
  logic             done_q;
  logic             err_q;

  logic             idle_like;
  logic             feeding;
  logic             capturing;
  logic             cap_ok;
  logic             excess;
  logic             host_we;
  logic             timeout;
  logic             last_layer;
  logic [AW-1:0]    raddr;
  logic             we0;
  logic             we1;
  logic [AW-1:0]    waddr0;
  logic [PIX_W-1:0] wdata0;
  logic [PIX_W-1:0] rdata0;
  logic [PIX_W-1:0] rdata1;
  logic [PIX_W-1:0] sel_rdata;

  assign idle_like  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign feeding    = (state == ST_FEED);
  assign capturing  = feeding || (state == ST_DRAIN);
  assign cap_ok     = bus.l_valid_out && capturing && (wr_cnt < CW'(DIM));
  assign excess     = bus.l_valid_out && !cap_ok;
  assign host_we    = bus.ld_en && idle_like;
  assign last_layer = (layer_idx == LW'(NUM_LAYERS - 1));

  // A capture landing in the final allowed cycle still counts toward completion.
  assign timeout = (state == ST_DRAIN) && (to_cnt == TW'(DRAIN_TO - 1)) &&
                   ((wr_cnt + CW'(cap_ok)) < CW'(DIM));

  // Destination is always the bank that is not the source; host only ever loads bank 0.
  assign raddr  = feeding ? rd_cnt[AW-1:0] : bus.res_addr;
  assign we0    = host_we || (cap_ok && src);
  assign waddr0 = host_we ? bus.ld_addr : wr_cnt[AW-1:0];
  assign wdata0 = host_we ? bus.ld_data : bus.l_data_out;
  assign we1    = cap_ok && !src;

  fmap_layer_sequencer_bank #(.DEPTH(DIM), .PIX_W(PIX_W), .AW(AW)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (we0),
    .waddr (waddr0),
    .wdata (wdata0),
    .raddr (raddr),
    .rdata (rdata0)
  );

  fmap_layer_sequencer_bank #(.DEPTH(DIM), .PIX_W(PIX_W), .AW(AW)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (we1),
    .waddr (wr_cnt[AW-1:0]),
    .wdata (bus.l_data_out),
    .raddr (raddr),
    .rdata (rdata1)
  );

  assign sel_rdata = src ? rdata1 : rdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      src       <= 1'b0;
      layer_idx <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      to_cnt    <= '0;
      feed_vld  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      feed_vld <= feeding;
      done_q   <= 1'b0;
      if (cap_ok) wr_cnt <= wr_cnt + CW'(1);
      if (excess) err_q <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            state     <= ST_CLR;
            src       <= 1'b0;
            layer_idx <= '0;
            err_q     <= 1'b0;
          end
        end
        ST_CLR: begin
          rd_cnt <= '0;
          wr_cnt <= '0;
          to_cnt <= '0;
          state  <= ST_FEED;
        end
        ST_FEED: begin
          rd_cnt <= rd_cnt + CW'(1);
          if (rd_cnt == CW'(DIM - 1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          to_cnt <= to_cnt + TW'(1);
          if (wr_cnt == CW'(DIM)) begin
            state <= ST_SWAP;
          end else if (timeout) begin
            state <= ST_ERR;
            err_q <= 1'b1;
          end
        end
        ST_SWAP: begin
          src <= ~src;
          if (last_layer) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            layer_idx <= layer_idx + LW'(1);
            state     <= ST_CLR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = !idle_like;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.layer_idx  = layer_idx;
  assign bus.layer_clr  = (state == ST_CLR);
  assign bus.l_valid_in = feed_vld;
  assign bus.l_data_in  = sel_rdata;
  assign bus.res_data   = sel_rdata;

endmodule

// File: tb/tb_fmap_layer_sequencer.sv
// Bench for the layer sequencer: a behavioural engine with configurable latency,
// per-lane increment and output-count faults, checked against per-lane arithmetic.
module tb_fmap_layer_sequencer;

  localparam int DATA_WIDTH = 8;
  localparam int LANES      = 4;
  localparam int WIDTH      = 7;
  localparam int NUM_LAYERS = 3;
  localparam int DRAIN_TO   = 100;
  localparam int PIX_W      = DATA_WIDTH * LANES;
  localparam int DIM        = WIDTH * WIDTH;
  localparam int AW         = 6;
  localparam int LW         = 2;
  localparam int BUDGET     = 5000;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_DROP   = 1;
  localparam int MODE_EXTRA  = 2;

  typedef struct {
    int               due;
    logic [PIX_W-1:0] d;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;

  int eng_add  = 0;
  int eng_lat  = 1;
  int eng_mode = MODE_NORMAL;

  int clr_total   = 0;
  int done_total  = 0;
  int vin_total   = 0;
  int burst_total = 0;
  int last_vin    = 0;
  int err_rise    = 0;
  int clr_hist[$];

  int snap_clr, snap_done, snap_vin, snap_burst;
  logic [PIX_W-1:0] pix [DIM];

  fmap_layer_sequencer_if #(.PIX_W(PIX_W), .AW(AW), .LW(LW)) bus ();

  fmap_layer_sequencer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .WIDTH      (WIDTH),
    .NUM_LAYERS (NUM_LAYERS),
    .DRAIN_TO   (DRAIN_TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PIX_W-1:0] lane_add(input logic [PIX_W-1:0] p, input int k);
    logic [PIX_W-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      r[l*DATA_WIDTH +: DATA_WIDTH] = p[l*DATA_WIDTH +: DATA_WIDTH] + DATA_WIDTH'(k);
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural engine: fixed latency, adds eng_add per lane, optional drop/extra output.
  initial begin
    ev_t q[$];
    ev_t ev;
    int  out_cnt;
    out_cnt = 0;
    bus.l_valid_out = 1'b0;
    bus.l_data_out  = '0;
    forever begin
      @(negedge clk);
      bus.l_valid_out = 1'b0;
      if (rst || bus.layer_clr) begin
        q.delete();
        out_cnt = 0;
      end else begin
        if (bus.l_valid_in)
          q.push_back('{due: cyc + eng_lat, d: lane_add(bus.l_data_in, eng_add)});
        if (q.size() > 0 && q[0].due == cyc) begin
          ev = q.pop_front();
          out_cnt++;
          if (!(eng_mode == MODE_DROP && out_cnt == DIM)) begin
            bus.l_valid_out = 1'b1;
            bus.l_data_out  = ev.d;
          end
          if (eng_mode == MODE_EXTRA && out_cnt == DIM)
            q.push_back('{due: cyc + 1, d: PIX_W'($urandom)});
        end
      end
    end
  end

  // Passive monitor of strobes and flags, accumulated over the whole run.
  initial begin
    logic prev_vin, prev_err;
    prev_vin = 1'b0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.layer_clr) begin
        clr_total++;
        clr_hist.push_back(int'(bus.layer_idx));
      end
      if (bus.done) done_total++;
      if (bus.l_valid_in) begin
        vin_total++;
        last_vin = cyc;
        if (!prev_vin) burst_total++;
      end
      if (bus.err && !prev_err) err_rise = cyc;
      prev_vin = bus.l_valid_in;
      prev_err = bus.err;
    end
  end

  task automatic apply_stimulus(input int add, input int lat, input int mode,
                                input bit poke, input bit stop_mid);
    int waited;
    bit poked;
    eng_add  = add;
    eng_lat  = lat;
    eng_mode = mode;
    snap_clr   = clr_total;
    snap_done  = done_total;
    snap_vin   = vin_total;
    snap_burst = burst_total;
    // Load top-down so the address-0 write coincides with start.
    for (int i = DIM - 1; i >= 0; i--) begin
      pix[i] = PIX_W'($urandom);
      @(negedge clk);
      bus.ld_en   = 1'b1;
      bus.ld_addr = AW'(i);
      bus.ld_data = pix[i];
      bus.start   = (i == 0);
    end
    waited = 0;
    poked  = 1'b0;
    do begin
      @(negedge clk);
      waited++;
      bus.ld_en = 1'b0;
      bus.start = 1'b0;
      if (stop_mid && bus.layer_idx == LW'(1) && bus.l_valid_in) return;
      if (poke && !poked && bus.layer_idx == LW'(2)) begin
        bus.ld_en   = 1'b1;
        bus.ld_addr = AW'(5);
        bus.ld_data = ~pix[5];
        bus.start   = 1'b1;
        poked       = 1'b1;
      end
    end while (bus.busy && waited < BUDGET);
    bus.ld_en = 1'b0;
    bus.start = 1'b0;
    if (stop_mid) check_output("mid_feed_reached", 64'(waited < BUDGET), 64'd0);
  endtask

  task automatic verify_run(input string tag, input int add, input bit exp_err);
    check_output({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_output({tag, "_err"}, 64'(bus.err), 64'(exp_err));
    check_output({tag, "_done_pulses"}, 64'(done_total - snap_done), 64'd1);
    check_output({tag, "_clr_pulses"}, 64'(clr_total - snap_clr), 64'(NUM_LAYERS));
    for (int k = 0; k < NUM_LAYERS; k++)
      check_output({tag, "_clr_layer_idx"}, 64'(clr_hist[snap_clr + k]), 64'(k));
    check_output({tag, "_vin_strobes"}, 64'(vin_total - snap_vin), 64'(DIM * NUM_LAYERS));
    check_output({tag, "_vin_bursts"}, 64'(burst_total - snap_burst), 64'(NUM_LAYERS));
    for (int i = 0; i < DIM; i++) begin
      @(negedge clk);
      bus.res_addr = AW'(i);
      @(posedge clk);
      #1;
      check_output({tag, "_res"}, 64'(bus.res_data), 64'(lane_add(pix[i], add * NUM_LAYERS)));
    end
  endtask

  initial begin
    int k;
    rst          = 1'b1;
    bus.ld_en    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.start    = 1'b0;
    bus.res_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", 64'(bus.busy), 64'd0);
    check_output("rst_done", 64'(bus.done), 64'd0);
    check_output("rst_err", 64'(bus.err), 64'd0);
    check_output("rst_layer_idx", 64'(bus.layer_idx), 64'd0);
    check_output("rst_layer_clr", 64'(bus.layer_clr), 64'd0);
    check_output("rst_valid_in", 64'(bus.l_valid_in), 64'd0);
    check_output("rst_res_data", 64'(bus.res_data), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    $display("[TB] identity engine, 1-cycle latency");
    apply_stimulus(0, 1, MODE_NORMAL, 1'b0, 1'b0);
    verify_run("ident", 0, 1'b0);

    $display("[TB] +1 engine with host writes and start while busy");
    apply_stimulus(1, 1, MODE_NORMAL, 1'b1, 1'b0);
    verify_run("add1", 1, 1'b0);

    $display("[TB] random increment, 60-cycle latency");
    k = int'($urandom_range(1, 255));
    apply_stimulus(k, 60, MODE_NORMAL, 1'b0, 1'b0);
    verify_run("lat60", k, 1'b0);

    $display("[TB] asynchronous reset during layer 1 feed");
    apply_stimulus(2, 3, MODE_NORMAL, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_output("midrst_busy", 64'(bus.busy), 64'd0);
    check_output("midrst_valid_in", 64'(bus.l_valid_in), 64'd0);
    check_output("midrst_layer_idx", 64'(bus.layer_idx), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    k = int'($urandom_range(1, 255));
    apply_stimulus(k, 2, MODE_NORMAL, 1'b0, 1'b0);
    verify_run("after_rst", k, 1'b0);

    $display("[TB] engine drops its last output");
    apply_stimulus(0, 5, MODE_DROP, 1'b0, 1'b0);
    check_output("drop_err", 64'(bus.err), 64'd1);
    check_output("drop_busy", 64'(bus.busy), 64'd0);
    check_output("drop_done_pulses", 64'(done_total - snap_done), 64'd0);
    check_output("drop_clr_pulses", 64'(clr_total - snap_clr), 64'd1);
    check_output("drop_timeout_cycles", 64'(err_rise - last_vin), 64'(DRAIN_TO));

    $display("[TB] restart from error state");
    k = int'($urandom_range(1, 255));
    apply_stimulus(k, 4, MODE_NORMAL, 1'b0, 1'b0);
    verify_run("from_err", k, 1'b0);

    $display("[TB] engine emits one extra output per layer");
    apply_stimulus(1, 1, MODE_EXTRA, 1'b0, 1'b0);
    verify_run("extra", 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
